uart_rx_param: RTL and testbench

UART_RX_PARAM -- requirements
Module: uart_rx_param

---
 rtl/uart_rx_param_if.sv | 23 ++
 rtl/uart_rx_param.sv | 230 +++++++++++++++++++++++
 tb/tb_uart_rx_param.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_param_if.sv
// Stream-side bundle of the UART receiver: payload handshake plus status pulses.
// master = receiver side, slave = consumer side.
interface uart_rx_param_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] data;
    logic                 valid;
    logic                 ready;
    logic                 errFrame;
    logic                 errParity;
    logic                 errOverrun;
    logic                 rxsync;

    modport master (
        output data, valid, errFrame, errParity, errOverrun, rxsync,
        input  ready
    );

    modport slave (
        input  data, valid, errFrame, errParity, errOverrun, rxsync,
        output ready
    );
endinterface

// File: rtl/uart_rx_param.sv
// Oversampling UART receiver with majority-vote bit decisions and a ready/valid output.
// Optional parity checking is enabled by defining the macro UART_RX_PARITY_EN.
module uart_rx_param #(
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int SAMPLES    = 3,
    parameter int PARITY_ODD = 0
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_rxd,
    input  logic                 i_rxpulse,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic                 o_err_frame,
    output logic                 o_err_parity,
    output logic                 o_err_overrun,
    output logic                 o_rxsync
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4,
        BREAK  = 3'd5
    } state_t;

    localparam logic [3:0] LAST_SAMPLE = 4'(SAMPLES - 1);
    localparam logic [3:0] LAST_DATA   = 4'(DATA_BITS - 1);
    localparam logic [3:0] LAST_STOP   = 4'(STOP_BITS - 1);
    localparam logic [3:0] HALF        = 4'(SAMPLES / 2);

    if (DATA_BITS < 5 || DATA_BITS > 9 || (STOP_BITS != 1 && STOP_BITS != 2) ||
        SAMPLES < 3 || SAMPLES > 15 || (SAMPLES % 2) == 0 ||
        (PARITY_ODD != 0 && PARITY_ODD != 1)) begin : g_badParams
        $error("uart_rx_param: illegal parameter value");
    end

    logic [2:0]           r_sync;
    logic                 w_rxd;
    state_t               r_state;
    state_t               w_stateNext;
    logic [3:0]           r_sampleCnt;
    logic [3:0]           r_bitCnt;
    logic [3:0]           w_ones;
    logic [SAMPLES-1:0]   r_samples;
    logic [SAMPLES-1:0]   w_samplesNext;
    logic [DATA_BITS-1:0] r_shift;
    logic                 w_sampling;
    logic                 w_decide;
    logic                 w_bit;
    logic                 w_startDet;
    logic                 w_frameDone;
    logic                 w_frameErr;
`ifdef UART_RX_PARITY_EN
    logic                 r_parBad;
    logic                 w_parErr;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_sync <= 3'b111;
        else       r_sync <= {r_sync[1:0], i_rxd};
    end

    assign w_rxd = r_sync[2];

    // The decision includes the sample taken on the deciding tick itself.
    assign w_samplesNext = {r_samples[SAMPLES-2:0], w_rxd};

    always_comb begin
        w_ones = '0;
        for (int i = 0; i < SAMPLES; i++) begin
            w_ones = w_ones + {3'b000, w_samplesNext[i]};
        end
        w_bit = (w_ones > HALF);
    end

    always_comb begin
        w_sampling = 1'b0;
        case (r_state)
            START, DATA, STOP: w_sampling = 1'b1;
`ifdef UART_RX_PARITY_EN
            PARITY:            w_sampling = 1'b1;
`endif
            default:           w_sampling = 1'b0;
        endcase
    end

    assign w_decide = w_sampling && i_rxpulse && (r_sampleCnt == LAST_SAMPLE);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= IDLE;
        else       r_state <= w_stateNext;
    end

    always_comb begin
        w_stateNext = r_state;
        w_startDet  = 1'b0;
        w_frameDone = 1'b0;
        w_frameErr  = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_parErr    = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                if (!w_rxd) begin
                    w_stateNext = START;
                    w_startDet  = 1'b1;
                end
            end
            START: begin
                if (w_decide) w_stateNext = w_bit ? IDLE : DATA;
            end
            DATA: begin
                if (w_decide && r_bitCnt == LAST_DATA) begin
`ifdef UART_RX_PARITY_EN
                    w_stateNext = PARITY;
`else
                    w_stateNext = STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (w_decide) w_stateNext = STOP;
            end
`endif
            STOP: begin
                if (w_decide) begin
                    if (!w_bit) begin
                        w_frameErr  = 1'b1;
                        w_stateNext = BREAK;
                    end else if (r_bitCnt == LAST_STOP) begin
                        w_stateNext = IDLE;
`ifdef UART_RX_PARITY_EN
                        if (r_parBad) w_parErr    = 1'b1;
                        else          w_frameDone = 1'b1;
`else
                        w_frameDone = 1'b1;
`endif
                    end
                end
            end
            BREAK: begin
                if (w_rxd) w_stateNext = IDLE;
            end
            default: w_stateNext = IDLE;
        endcase
    end

    // Bit counter is reused: data bits in DATA, then stop bits in STOP.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sampleCnt <= '0;
            r_samples   <= '0;
            r_bitCnt    <= '0;
            r_shift     <= '0;
`ifdef UART_RX_PARITY_EN
            r_parBad    <= 1'b0;
`endif
        end else if (w_startDet) begin
            r_sampleCnt <= '0;
            r_samples   <= '0;
            r_bitCnt    <= '0;
            r_shift     <= '0;
`ifdef UART_RX_PARITY_EN
            r_parBad    <= 1'b0;
`endif
        end else if (w_sampling && i_rxpulse) begin
            if (w_decide) begin
                r_sampleCnt <= '0;
                r_samples   <= '0;
                case (r_state)
                    DATA: begin
                        r_shift  <= {w_bit, r_shift[DATA_BITS-1:1]};
                        r_bitCnt <= (r_bitCnt == LAST_DATA) ? 4'd0 : r_bitCnt + 4'd1;
                    end
`ifdef UART_RX_PARITY_EN
                    PARITY: r_parBad <= ((^r_shift) ^ w_bit) != 1'(PARITY_ODD);
`endif
                    STOP:    r_bitCnt <= r_bitCnt + 4'd1;
                    default: ;
                endcase
            end else begin
                r_sampleCnt <= r_sampleCnt + 4'd1;
                r_samples   <= w_samplesNext;
            end
        end
    end

    // A completed frame wins over the drop of o_valid when the consumer is accepting.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_data        <= '0;
            o_valid       <= 1'b0;
            o_err_frame   <= 1'b0;
            o_err_overrun <= 1'b0;
            o_rxsync      <= 1'b0;
        end else begin
            o_err_frame   <= w_frameErr;
            o_err_overrun <= 1'b0;
            o_rxsync      <= w_startDet;
            if (w_frameDone) begin
                if (o_valid && !i_ready) begin
                    o_err_overrun <= 1'b1;
                end else begin
                    o_data  <= r_shift;
                    o_valid <= 1'b1;
                end
            end else if (o_valid && i_ready) begin
                o_valid <= 1'b0;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) o_err_parity <= 1'b0;
        else       o_err_parity <= w_parErr;
    end
`else
    assign o_err_parity = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed self-checking bench for uart_rx_param: a default instance (A) and a
// 7-bit / 2-stop / 5-sample instance (B) sharing one clock and oversampling tick.
module tb_uart_rx_param;

   logic clk = 1'b0;
   logic rstA, rstB, rxdA, rxdB, rxpulse;

   uart_rx_param_if #(.DATA_BITS(8)) busA ();
   uart_rx_param_if #(.DATA_BITS(7)) busB ();

   uart_rx_param dutA (
      .i_clk(clk), .i_rst(rstA), .i_rxd(rxdA), .i_rxpulse(rxpulse),
      .o_data(busA.data), .o_valid(busA.valid), .i_ready(busA.ready),
      .o_err_frame(busA.errFrame), .o_err_parity(busA.errParity),
      .o_err_overrun(busA.errOverrun), .o_rxsync(busA.rxsync)
   );

   uart_rx_param #(.DATA_BITS(7), .STOP_BITS(2), .SAMPLES(5)) dutB (
      .i_clk(clk), .i_rst(rstB), .i_rxd(rxdB), .i_rxpulse(rxpulse),
      .o_data(busB.data), .o_valid(busB.valid), .i_ready(busB.ready),
      .o_err_frame(busB.errFrame), .o_err_parity(busB.errParity),
      .o_err_overrun(busB.errOverrun), .o_rxsync(busB.rxsync)
   );

   always #5 clk = ~clk;

   // Oversampling tick: one cycle high every eight clocks, changed on negedges.
   initial begin
      rxpulse = 1'b0;
      forever begin
         repeat (7) @(negedge clk);
         rxpulse = 1'b1;
         @(negedge clk);
         rxpulse = 1'b0;
      end
   end

   // Event counters sampled on the falling edge, away from the DUT update edge.
   int syncA = 0, validA = 0, acceptA = 0, ferrA = 0, perrA = 0, ovrA = 0;
   int syncB = 0, validB = 0, acceptB = 0, ferrB = 0;
   int lastAccA = 0, lastAccB = 0;

   always @(negedge clk) begin
      if (busA.rxsync)     syncA++;
      if (busA.valid)      validA++;
      if (busA.errFrame)   ferrA++;
      if (busA.errParity)  perrA++;
      if (busA.errOverrun) ovrA++;
      if (busA.valid && busA.ready) begin
         acceptA++;
         lastAccA = int'(busA.data);
      end
      if (busB.rxsync)     syncB++;
      if (busB.valid)      validB++;
      if (busB.errFrame)   ferrB++;
      if (busB.valid && busB.ready) begin
         acceptB++;
         lastAccB = int'(busB.data);
      end
   end

   int testsRun = 0, testsFailed = 0;
   int bSyncA, bValidA, bAcceptA, bFerrA, bPerrA, bOvrA;
   int bSyncB, bValidB, bAcceptB, bFerrB;

   task automatic checkOutput(input string tag, input int observed, input int expected);
      testsRun++;
      if (observed !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic snapshot();
      bSyncA = syncA; bValidA = validA; bAcceptA = acceptA;
      bFerrA = ferrA; bPerrA = perrA; bOvrA = ovrA;
      bSyncB = syncB; bValidB = validB; bAcceptB = acceptB; bFerrB = ferrB;
   endtask

   task automatic waitTick();
      do @(posedge clk); while (!rxpulse);
   endtask

   // Drive one line level for a number of ticks; returns just after the last tick.
   task automatic sendBit(input bit sel, input logic b, input int ticks);
      if (sel) rxdB = b;
      else     rxdA = b;
      repeat (ticks) waitTick();
      @(negedge clk);
   endtask

   // One frame: start, LSB-first payload, optional parity, stop bits at stopVal.
   task automatic applyStimulus(input bit sel, input logic [8:0] data, input int nbits,
                                input int nstop, input logic stopVal, input logic parityFlip);
      int   s;
      logic p;
      s = sel ? 5 : 3;
      p = parityFlip;
      sendBit(sel, 1'b0, s);
      for (int i = 0; i < nbits; i++) begin
         sendBit(sel, data[i], s);
         p = p ^ data[i];
      end
`ifdef UART_RX_PARITY_EN
      sendBit(sel, p, s);
`endif
      for (int i = 0; i < nstop; i++) sendBit(sel, stopVal, s);
   endtask

   initial begin
      rstA = 1'b1; rstB = 1'b1; rxdA = 1'b1; rxdB = 1'b1;
      busA.ready = 1'b1; busB.ready = 1'b1;
      repeat (3) @(negedge clk);

      checkOutput("rst_dataA",    int'(busA.data), 0);
      checkOutput("rst_validA",   int'(busA.valid), 0);
      checkOutput("rst_ferrA",    int'(busA.errFrame), 0);
      checkOutput("rst_perrA",    int'(busA.errParity), 0);
      checkOutput("rst_ovrA",     int'(busA.errOverrun), 0);
      checkOutput("rst_syncA",    int'(busA.rxsync), 0);
      checkOutput("rst_validB",   int'(busB.valid), 0);

      rstA = 1'b0; rstB = 1'b0;
      waitTick();
      @(negedge clk);
      sendBit(0, 1'b1, 6);
      checkOutput("post_rst_sync",  syncA, 0);
      checkOutput("post_rst_valid", validA, 0);

      // Basic 0xA5 frame with the consumer always ready
      snapshot();
      applyStimulus(0, 9'h0A5, 8, 1, 1'b1, 1'b0);
      sendBit(0, 1'b1, 6);
      checkOutput("a5_valid_cycles", validA - bValidA, 1);
      checkOutput("a5_data",         lastAccA, 8'hA5);
      checkOutput("a5_sync",         syncA - bSyncA, 1);
      checkOutput("a5_ferr",         ferrA - bFerrA, 0);
      checkOutput("a5_ovr",          ovrA - bOvrA, 0);
      checkOutput("a5_perr",         perrA - bPerrA, 0);

      // One-tick low glitch is a false start
      snapshot();
      rxdA = 1'b0;
      waitTick();
      @(negedge clk);
      rxdA = 1'b1;
      sendBit(0, 1'b1, 9);
      checkOutput("glitch_sync",  syncA - bSyncA, 1);
      checkOutput("glitch_valid", validA - bValidA, 0);
      checkOutput("glitch_ferr",  ferrA - bFerrA, 0);

      // Bad stop bit followed by a long break, then a clean frame
      snapshot();
      applyStimulus(0, 9'h03C, 8, 1, 1'b0, 1'b0);
      sendBit(0, 1'b0, 40);
      sendBit(0, 1'b1, 9);
      checkOutput("break_ferr",  ferrA - bFerrA, 1);
      checkOutput("break_valid", validA - bValidA, 0);
      snapshot();
      applyStimulus(0, 9'h011, 8, 1, 1'b1, 1'b0);
      sendBit(0, 1'b1, 6);
      checkOutput("after_break_accept", acceptA - bAcceptA, 1);
      checkOutput("after_break_data",   lastAccA, 8'h11);
      checkOutput("after_break_ferr",   ferrA - bFerrA, 0);

      // Backpressure: second frame overruns and is dropped
      busA.ready = 1'b0;
      snapshot();
      applyStimulus(0, 9'h001, 8, 1, 1'b1, 1'b0);
      sendBit(0, 1'b1, 6);
      checkOutput("bp_valid_first", int'(busA.valid), 1);
      checkOutput("bp_data_first",  int'(busA.data), 8'h01);
      applyStimulus(0, 9'h002, 8, 1, 1'b1, 1'b0);
      sendBit(0, 1'b1, 6);
      checkOutput("bp_overrun",    ovrA - bOvrA, 1);
      checkOutput("bp_data_held",  int'(busA.data), 8'h01);
      checkOutput("bp_valid_held", int'(busA.valid), 1);
      busA.ready = 1'b1;
      @(negedge clk);
      checkOutput("bp_valid_drop", int'(busA.valid), 0);
      sendBit(0, 1'b1, 3);

`ifdef UART_RX_PARITY_EN
      // Wrong parity bit is rejected, correct one is accepted
      snapshot();
      applyStimulus(0, 9'h007, 8, 1, 1'b1, 1'b1);
      sendBit(0, 1'b1, 6);
      checkOutput("par_bad_perr",  perrA - bPerrA, 1);
      checkOutput("par_bad_valid", validA - bValidA, 0);
      snapshot();
      applyStimulus(0, 9'h007, 8, 1, 1'b1, 1'b0);
      sendBit(0, 1'b1, 6);
      checkOutput("par_good_perr", perrA - bPerrA, 0);
      checkOutput("par_good_data", lastAccA, 8'h07);
`else
      checkOutput("par_absent_perr", perrA, 0);
`endif

      // Instance B: reset mid-frame during bit 4, then a full resend
      checkOutput("b_idle_sync", syncB, 0);
      sendBit(1, 1'b0, 5);
      for (int i = 0; i < 4; i++) sendBit(1, (8'h55 >> i) & 8'h01, 5);
      rxdB = 1'b1;
      waitTick();
      waitTick();
      @(negedge clk);
      rstB = 1'b1;
      @(negedge clk);
      checkOutput("b_rst_valid", int'(busB.valid), 0);
      checkOutput("b_rst_sync",  int'(busB.rxsync), 0);
      @(negedge clk);
      rstB = 1'b0;
      snapshot();
      waitTick();
      @(negedge clk);
      sendBit(1, 1'b1, 20);
      checkOutput("b_abort_sync",  syncB - bSyncB, 0);
      checkOutput("b_abort_valid", validB - bValidB, 0);
      checkOutput("b_abort_ferr",  ferrB - bFerrB, 0);
      snapshot();
      applyStimulus(1, 9'h055, 7, 2, 1'b1, 1'b0);
      sendBit(1, 1'b1, 10);
      checkOutput("b_resend_accept", acceptB - bAcceptB, 1);
      checkOutput("b_resend_data",   lastAccB, 7'h55);
      checkOutput("b_resend_ferr",   ferrB - bFerrB, 0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
